egd_bit_feeder: RTL

EGD_BIT_FEEDER -- requirements
Module: egd_bit_feeder

---
 rtl/egd_bit_feeder.sv | 113 +++++++++++
 1 files changed

// File: rtl/egd_bit_feeder.sv
`default_nettype none
// ============================================================================
// Module   : egd_bit_feeder
// Purpose  : Bitstream window buffer for an Exp-Golomb decoder. Accepts 16-bit
//            MSB-first stream words and presents the next 16 unconsumed bits
//            as a window. The decoder retires 1..16 bits per cycle.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   wb_clk_i    in   1   clock, rising edge
//   wb_rst_n    in   1   asynchronous active-low reset
//   in_data     in  16   stream word, MSB = earliest bit
//   in_valid    in   1   in_data valid
//   in_ready    out  1   a word can be accepted this cycle
//   flush       in   1   synchronous discard of all buffered bits
//   win_data    out 16   next 16 unconsumed bits, MSB-first
//   win_valid   out  1   win_data holds 16 valid bits
//   consume     in   1   retire consume_len bits
//   consume_len in   5   bits to retire, 1..16
//   fill_level  out  6   buffered valid bits, 0..32
//   bit_count   out 16   running count of retired bits (wraps)
//   err         out  1   sticky illegal-consume flag
// ============================================================================
module egd_bit_feeder (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        flush,
  output logic [15:0] win_data,
  output logic        win_valid,
  input  logic        consume,
  input  logic [4:0]  consume_len,
  output logic [5:0]  fill_level,
  output logic [15:0] bit_count,
  output logic        err
);

  localparam logic [5:0] WORD_BITS = 6'd16;

  // Valid bits live in buf_q[31 -: fill_q]; everything below is kept zero so
  // a new word can simply be OR-ed in behind them.
  logic [31:0] buf_q,       buf_d;
  logic [5:0]  fill_q,      fill_d;
  logic [15:0] bit_count_q, bit_count_d;
  logic        err_q,       err_d;

  logic        len_legal;
  logic        consume_ok;
  logic        push;
  logic [31:0] buf_c;
  logic [5:0]  fill_c;

  assign win_data   = buf_q[31:16];
  assign win_valid  = (fill_q >= WORD_BITS);
  assign in_ready   = (fill_q <= WORD_BITS) && !flush;
  assign fill_level = fill_q;
  assign bit_count  = bit_count_q;
  assign err        = err_q;

  assign len_legal  = (consume_len != 5'd0) && (consume_len <= 5'd16);
  assign consume_ok = consume && win_valid && len_legal;
  assign push       = in_valid && in_ready;

  always_comb begin
    buf_d       = buf_q;
    fill_d      = fill_q;
    bit_count_d = bit_count_q;
    err_d       = err_q;
    buf_c       = buf_q;
    fill_c      = fill_q;

    if (flush) begin
      // flush wins over consume; push is already blocked through in_ready
      buf_d  = 32'd0;
      fill_d = 6'd0;
      err_d  = 1'b0;
    end else begin
      if (consume_ok) begin
        buf_c       = buf_q << consume_len;
        fill_c      = fill_q - {1'b0, consume_len};
        bit_count_d = bit_count_q + {11'd0, consume_len};
      end else if (consume) begin
        err_d = 1'b1;
      end
      // Push lands directly behind the bits that survive this cycle's consume.
      // in_ready guarantees fill_c <= 16, so the word fits entirely.
      if (push) begin
        buf_c  = buf_c | ({in_data, 16'd0} >> fill_c);
        fill_c = fill_c + WORD_BITS;
      end
      buf_d  = buf_c;
      fill_d = fill_c;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      buf_q       <= 32'd0;
      fill_q      <= 6'd0;
      bit_count_q <= 16'd0;
      err_q       <= 1'b0;
    end else begin
      buf_q       <= buf_d;
      fill_q      <= fill_d;
      bit_count_q <= bit_count_d;
      err_q       <= err_d;
    end
  end

endmodule
`default_nettype wire
